// File: rtl/bin_clock_pkg.sv
// Shared constants and field helpers for the binary time-of-day clock.
// Time is stored as 24-hour hh:mm:ss; the helpers wrap at each field's own width.
package bin_clock_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    // One set-mode step on a 0..max_v field. Wrap is decided before the update.
    function automatic logic [SEC_W-1:0] step_60(input logic [SEC_W-1:0] v,
                                                 input logic [SEC_W-1:0] max_v,
                                                 input logic up);
        if (up)
            return (v == max_v) ? 6'd0 : v + 6'd1;
        else
            return (v == 6'd0) ? max_v : v - 6'd1;
    endfunction

    function automatic logic [HOUR_W-1:0] step_hour(input logic [HOUR_W-1:0] v,
                                                    input logic up);
        if (up)
            return (v == HOUR_MAX) ? 5'd0 : v + 5'd1;
        else
            return (v == 5'd0) ? HOUR_MAX : v - 5'd1;
    endfunction

    // 24h -> 12h display hour: 0 and 12 both show as 12.
    function automatic logic [HOUR_W-1:0] hour_12h(input logic [HOUR_W-1:0] hh);
        logic [HOUR_W-1:0] r;
        r = (hh >= 5'd12) ? hh - 5'd12 : hh;
        return (r == 5'd0) ? 5'd12 : r;
    endfunction

endpackage

// File: rtl/bin_clock_btn_edge.sv
// Two-flop synchroniser for an asynchronous button level, followed by a
// rising-edge detector. All flops clear on reset so a held button looks like a new press.
module bin_clock_btn_edge (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic sync2_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    assign rise = sync2 & ~sync2_d;

endmodule

// File: rtl/tt_bin_clock_gen2.sv
// Binary time-of-day clock: prescaled seconds counter with carry, set mode with
// per-field button stepping, 12/24h display formatting and second/day strobes.
module tt_bin_clock_gen2
    import bin_clock_pkg::*;
#(
    parameter int CLK_HZ = 100
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       time_set,
    input  logic       id_switch,
    input  logic       hour_id,
    input  logic       minute_id,
    input  logic       seconds_id,
    input  logic       mode_24h,
    output logic [4:0] hour_out,
    output logic [5:0] minute_out,
    output logic [5:0] seconds_out,
    output logic       pm_out,
    output logic       sec_tick,
    output logic       day_tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0]  presc;
    logic [HOUR_W-1:0] hh;
    logic [MIN_W-1:0]  mm;
    logic [SEC_W-1:0]  ss;
    logic              hour_rise;
    logic              minute_rise;
    logic              seconds_rise;

    bin_clock_btn_edge u_hour_btn (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .btn     (hour_id),
        .rise    (hour_rise)
    );

    bin_clock_btn_edge u_minute_btn (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .btn     (minute_id),
        .rise    (minute_rise)
    );

    bin_clock_btn_edge u_seconds_btn (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .btn     (seconds_id),
        .rise    (seconds_rise)
    );

    // sec_tick/day_tick are single-cycle strobes: high for the one cycle after
    // the advancing edge; there is no back-pressure on them.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            presc    <= '0;
            hh       <= '0;
            mm       <= '0;
            ss       <= '0;
            sec_tick <= 1'b0;
            day_tick <= 1'b0;
        end else if (time_set) begin
            presc    <= '0;
            sec_tick <= 1'b0;
            day_tick <= 1'b0;
            // Simultaneous edges: seconds beats minutes beats hours; losers are dropped.
            if (seconds_rise)
                ss <= step_60(ss, SEC_MAX, id_switch);
            else if (minute_rise)
                mm <= step_60(mm, MIN_MAX, id_switch);
            else if (hour_rise)
                hh <= step_hour(hh, id_switch);
        end else if (presc == PRESC_LAST) begin
            presc    <= '0;
            sec_tick <= 1'b1;
            day_tick <= (hh == HOUR_MAX) && (mm == MIN_MAX) && (ss == SEC_MAX);
            if (ss == SEC_MAX) begin
                ss <= '0;
                if (mm == MIN_MAX) begin
                    mm <= '0;
                    hh <= (hh == HOUR_MAX) ? 5'd0 : hh + 5'd1;
                end else begin
                    mm <= mm + 6'd1;
                end
            end else begin
                ss <= ss + 6'd1;
            end
        end else begin
            presc    <= presc + CNT_W'(1);
            sec_tick <= 1'b0;
            day_tick <= 1'b0;
        end
    end

    assign hour_out    = mode_24h ? hh : hour_12h(hh);
    assign pm_out      = ~mode_24h & (hh >= 5'd12);
    assign minute_out  = mm;
    assign seconds_out = ss;

endmodule

// File: tb/tb_tt_bin_clock_gen2.sv
// Randomised scoreboard bench: a seconds-of-day reference model predicts every
// cycle's outputs, and a negedge monitor pops and compares them.
module tb_tt_bin_clock_gen2;

    localparam int CLK_HZ = 4;

    logic       clk_i      = 1'b0;
    logic       reset_i    = 1'b1;
    logic       time_set   = 1'b0;
    logic       id_switch  = 1'b0;
    logic       hour_id    = 1'b0;
    logic       minute_id  = 1'b0;
    logic       seconds_id = 1'b0;
    logic       mode_24h   = 1'b1;
    logic [4:0] hour_out;
    logic [5:0] minute_out;
    logic [5:0] seconds_out;
    logic       pm_out;
    logic       sec_tick;
    logic       day_tick;

    int checks = 0;
    int errors = 0;

    // {hh[4:0], mm[5:0], ss[5:0], sec_tick, day_tick}, formatting applied by the monitor
    logic [18:0] exp_q[$];

    int tod = 0;
    int cyc = 0;
    int hq[$] = '{0, 0, 0, 0};
    int mq[$] = '{0, 0, 0, 0};
    int sq[$] = '{0, 0, 0, 0};

    tt_bin_clock_gen2 #(.CLK_HZ(CLK_HZ)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .time_set    (time_set),
        .id_switch   (id_switch),
        .hour_id     (hour_id),
        .minute_id   (minute_id),
        .seconds_id  (seconds_id),
        .mode_24h    (mode_24h),
        .hour_out    (hour_out),
        .minute_out  (minute_out),
        .seconds_out (seconds_out),
        .pm_out      (pm_out),
        .sec_tick    (sec_tick),
        .day_tick    (day_tick)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    always @(posedge clk_i) begin
        int h, m, s, n;
        bit hr, mr, sr, st, dt;
        logic [4:0] eh;
        logic [5:0] em, es;
        hq.push_back(int'(hour_id));
        mq.push_back(int'(minute_id));
        sq.push_back(int'(seconds_id));
        n = hq.size();
        st = 1'b0;
        dt = 1'b0;
        // a press counts at edge n if sampled high at n-2 and low at n-3
        hr = (hq[n-3] == 1) && (hq[n-4] == 0);
        mr = (mq[n-3] == 1) && (mq[n-4] == 0);
        sr = (sq[n-3] == 1) && (sq[n-4] == 0);
        if (reset_i) begin
            for (int i = 1; i <= 3; i++) begin
                hq[n-i] = 0;
                mq[n-i] = 0;
                sq[n-i] = 0;
            end
            tod = 0;
            cyc = 0;
        end else if (time_set) begin
            cyc = 0;
            h = tod / 3600;
            m = (tod / 60) % 60;
            s = tod % 60;
            if (sr)      s = id_switch ? (s + 1) % 60 : (s + 59) % 60;
            else if (mr) m = id_switch ? (m + 1) % 60 : (m + 59) % 60;
            else if (hr) h = id_switch ? (h + 1) % 24 : (h + 23) % 24;
            tod = h * 3600 + m * 60 + s;
        end else begin
            cyc++;
            if (cyc == CLK_HZ) begin
                cyc = 0;
                st = 1'b1;
                dt = (tod == 86399);
                tod = (tod + 1) % 86400;
            end
        end
        while (hq.size() > 6) begin
            void'(hq.pop_front());
            void'(mq.pop_front());
            void'(sq.pop_front());
        end
        eh = 5'(tod / 3600);
        em = 6'((tod / 60) % 60);
        es = 6'(tod % 60);
        exp_q.push_back({eh, em, es, st, dt});
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk_i) begin
        logic [18:0] e;
        logic [4:0]  eh, ehour;
        logic        epm;
        logic [19:0] expv, actv;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL no_expected: DUT presented outputs at %0t with empty queue", $time);
        end else begin
            e  = exp_q.pop_front();
            eh = e[18:14];
            if (mode_24h) begin
                ehour = eh;
                epm   = 1'b0;
            end else begin
                ehour = 5'(((eh % 12) == 0) ? 12 : (eh % 12));
                epm   = (eh >= 12);
            end
            expv = {ehour, e[13:8], e[7:2], epm, e[1], e[0]};
            actv = {hour_out, minute_out, seconds_out, pm_out, sec_tick, day_tick};
            if (actv !== expv) begin
                errors++;
                $display("FAIL outputs @%0t: got h=%0d m=%0d s=%0d pm=%0b st=%0b dt=%0b, expected h=%0d m=%0d s=%0d pm=%0b st=%0b dt=%0b",
                         $time, hour_out, minute_out, seconds_out, pm_out, sec_tick, day_tick,
                         ehour, e[13:8], e[7:2], epm, e[1], e[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #2;
        end
    endtask

    // mask = {hour, minute, seconds}
    task automatic press(input logic [2:0] mask, input logic up);
        id_switch = up;
        {hour_id, minute_id, seconds_id} = mask;
        cycles(2);
        {hour_id, minute_id, seconds_id} = 3'b000;
        cycles(3);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cycles(3);
        reset_i = 1'b0;
        cycles(240);

        // preload 23:59:58 from 00:01:00, then run across midnight
        time_set = 1'b1;
        cycles(2);
        press(3'b100, 1'b0);
        press(3'b010, 1'b0);
        press(3'b010, 1'b0);
        press(3'b001, 1'b0);
        press(3'b001, 1'b0);
        time_set = 1'b0;
        cycles(12);

        // set-mode decrement wraps and simultaneous-press priority
        time_set = 1'b1;
        cycles(1);
        press(3'b001, 1'b0);
        press(3'b100, 1'b0);
        press(3'b101, 1'b1);
        press(3'b111, 1'b0);

        // walk the hour through a full day, alternating display modes
        for (int i = 0; i < 25; i++) begin
            press(3'b100, 1'b1);
            mode_24h = ~mode_24h;
            cycles(1);
        end
        mode_24h = 1'b0;

        // reset while a minute button is held in set mode
        minute_id = 1'b1;
        cycles(3);
        reset_i = 1'b1;
        cycles(2);
        time_set = 1'b0;
        reset_i  = 1'b0;
        cycles(4);
        time_set = 1'b1;
        cycles(5);
        minute_id = 1'b0;
        cycles(2);
        press(3'b010, 1'b1);
        time_set = 1'b0;
        cycles(9);

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) time_set = ~time_set;
            if ($urandom_range(0, 3) == 0)  hour_id = ~hour_id;
            if ($urandom_range(0, 3) == 0)  minute_id = ~minute_id;
            if ($urandom_range(0, 2) == 0)  seconds_id = ~seconds_id;
            if ($urandom_range(0, 7) == 0)  mode_24h = ~mode_24h;
            if ($urandom_range(0, 4) == 0)  id_switch = 1'($urandom_range(0, 1));
            reset_i = ($urandom_range(0, 299) == 0);
            cycles(1);
        end
        reset_i = 1'b0;
        cycles(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
